// File: rtl/gpu_pixel_writer.sv
// Buffers generated pixels in a small FIFO and writes them to the framebuffer one word at a time.
// Latency: a pixel pushed into an empty, idle writer is on the memory bus one edge later.
// Backpressure: ready_o drops when the FIFO is full; mem_we_o holds the current write until mem_ack_i.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_pixel_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 20
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         pix_valid_i,
  input  logic [`WIDTH_BITS-1:0]       x_i,
  input  logic [`HEIGHT_BITS-1:0]      y_i,
  input  logic [`CHANNEL_BITS-1:0]     r_i,
  input  logic [`CHANNEL_BITS-1:0]     g_i,
  input  logic [`CHANNEL_BITS-1:0]     b_i,
  input  logic                         gen_done_i,
  output logic                         ready_o,
  output logic [ADDR_BITS-1:0]         mem_addr_o,
  output logic [3*`CHANNEL_BITS-1:0]   mem_data_o,
  output logic                         mem_we_o,
  input  logic                         mem_ack_i,
  output logic                         overflow_o,
  output logic                         frame_done_o,
  output logic                         idle_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] WIDTH_A = ADDR_BITS'(`WIDTH);

  typedef struct packed {
    logic [`WIDTH_BITS-1:0]   x;
    logic [`HEIGHT_BITS-1:0]  y;
    logic [`CHANNEL_BITS-1:0] r;
    logic [`CHANNEL_BITS-1:0] g;
    logic [`CHANNEL_BITS-1:0] b;
  } pix_t;

  typedef enum logic {IDLE, WRITE} state_t;

  pix_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  state_t           state_q, state_d;
  logic             done_pending_q;
  logic             in_range, push, pop, empty, done_fire;
  pix_t             pix_in, head;

  assign in_range = (32'(x_i) < 32'(`WIDTH)) && (32'(y_i) < 32'(`HEIGHT));
  assign ready_o  = count_q < DEPTH_C;
  assign empty    = (count_q == '0);
  assign push     = pix_valid_i && ready_o && in_range;
  assign pix_in   = '{x: x_i, y: y_i, r: r_i, g: g_i, b: b_i};
  assign head     = fifo_q[rd_ptr_q];
  assign idle_o   = (state_q == IDLE) && empty && !done_pending_q;
  // Frame is complete only once the generator is quiet and nothing is queued or in flight.
  assign done_fire = done_pending_q && empty && (state_q == IDLE) && !gen_done_i;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack_i) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage carries no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= pix_in;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      mem_we_o       <= 1'b0;
      overflow_o     <= 1'b0;
      done_pending_q <= 1'b0;
      frame_done_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (pop) begin
        mem_addr_o <= ADDR_BITS'(head.y) * WIDTH_A + ADDR_BITS'(head.x);
        mem_data_o <= {head.r, head.g, head.b};
        mem_we_o   <= 1'b1;
      end else if (state_q == WRITE && mem_ack_i) begin
        mem_we_o   <= 1'b0;
      end
      if (pix_valid_i && in_range && !ready_o) overflow_o <= 1'b1;
      done_pending_q <= gen_done_i || (done_pending_q && !done_fire);
      frame_done_o   <= done_fire;
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed and randomized checks of gpu_pixel_writer against a queue-based model of expected framebuffer writes.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module tb_gpu_pixel_writer;
  localparam int W  = `WIDTH;
  localparam int H  = `HEIGHT;
  localparam int AB = 20;
  localparam int CB = `CHANNEL_BITS;

  logic                       clk = 1'b0;
  logic                       n_rst;
  logic                       pix_valid_i;
  logic [`WIDTH_BITS-1:0]     x_i;
  logic [`HEIGHT_BITS-1:0]    y_i;
  logic [CB-1:0]              r_i, g_i, b_i;
  logic                       gen_done_i;
  logic                       ready_o;
  logic [AB-1:0]              mem_addr_o;
  logic [3*CB-1:0]            mem_data_o;
  logic                       mem_we_o;
  logic                       mem_ack_i;
  logic                       overflow_o;
  logic                       frame_done_o;
  logic                       idle_o;

  gpu_pixel_writer #(.FIFO_DEPTH(4), .ADDR_BITS(AB)) dut (
    .clk(clk), .n_rst(n_rst), .pix_valid_i(pix_valid_i), .x_i(x_i), .y_i(y_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i), .gen_done_i(gen_done_i), .ready_o(ready_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_ack_i(mem_ack_i), .overflow_o(overflow_o), .frame_done_o(frame_done_o),
    .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int fd_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] log_q[$];

  // Record every completed write and count cycles of the strobes.
  always @(posedge clk) begin
    if (mem_we_o) we_cnt++;
    if (frame_done_o) fd_cnt++;
    if (mem_we_o && mem_ack_i) log_q.push_back(64'({mem_addr_o, mem_data_o}));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input int x, input int y, input int r, input int g, input int b);
    logic [AB-1:0]   a;
    logic [3*CB-1:0] d;
    a = AB'(y * W + x);
    d = {CB'(r), CB'(g), CB'(b)};
    return 64'({a, d});
  endfunction

  task automatic expect_pix(input int x, input int y, input int r, input int g, input int b);
    if (x < W && y < H) exp_q.push_back(mk(x, y, r, g, b));
  endtask

  task automatic drive(input int x, input int y, input int r, input int g, input int b);
    pix_valid_i = 1'b1;
    x_i = `WIDTH_BITS'(x);
    y_i = `HEIGHT_BITS'(y);
    r_i = CB'(r);
    g_i = CB'(g);
    b_i = CB'(b);
  endtask

  task automatic send(input int x, input int y, input int r, input int g, input int b);
    drive(x, y, r, g, b);
    tick();
    pix_valid_i = 1'b0;
  endtask

  task automatic compare_log(input string tag);
    int n;
    chk({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, log_q[i], exp_q[i]);
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit   want, oor;
    int   x, y;

    n_rst = 1'b0; pix_valid_i = 1'b0; x_i = '0; y_i = '0;
    r_i = '0; g_i = '0; b_i = '0; gen_done_i = 1'b0; mem_ack_i = 1'b0;
    tick(); tick();
    chk("rst_we", 64'(mem_we_o), 64'(0));
    chk("rst_addr", 64'(mem_addr_o), 64'(0));
    chk("rst_data", 64'(mem_data_o), 64'(0));
    chk("rst_ovf", 64'(overflow_o), 64'(0));
    chk("rst_fd", 64'(frame_done_o), 64'(0));
    chk("rst_idle", 64'(idle_o), 64'(1));
    chk("rst_ready", 64'(ready_o), 64'(1));
    n_rst = 1'b1;
    tick();

    // Single pixel with ack tied high.
    mem_ack_i = 1'b1;
    log_q.delete();
    we_cnt = 0;
    send(3, 2, 1, 2, 3);
    expect_pix(3, 2, 1, 2, 3);
    chk("single_we_early", 64'(mem_we_o), 64'(0));
    tick();
    chk("single_we", 64'(mem_we_o), 64'(1));
    chk("single_addr", 64'(mem_addr_o), 64'(2 * W + 3));
    chk("single_data", 64'(mem_data_o), 64'(24'h010203));
    tick();
    chk("single_we_off", 64'(mem_we_o), 64'(0));
    repeat (4) tick();
    chk("single_we_cycles", 64'(we_cnt), 64'(1));
    compare_log("single_log");

    // 2x2 rectangle, then two back-to-back done pulses that must merge.
    fd_cnt = 0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++) begin
        send(10 + i, 20 + j, 16 * j + i, 5, 250);
        expect_pix(10 + i, 20 + j, 16 * j + i, 5, 250);
      end
    gen_done_i = 1'b1;
    tick(); tick();
    gen_done_i = 1'b0;
    chk("rect_fd_early", 64'(fd_cnt), 64'(0));
    repeat (20) tick();
    chk("rect_fd_pulses", 64'(fd_cnt), 64'(1));
    chk("rect_idle", 64'(idle_o), 64'(1));
    compare_log("rect_log");

    // Out-of-range coordinates are silently discarded.
    send(W, 5, 9, 9, 9);
    send(7, H, 9, 9, 9);
    chk("oor_idle", 64'(idle_o), 64'(1));
    repeat (4) tick();
    chk("oor_ovf", 64'(overflow_o), 64'(0));
    chk("oor_we", 64'(mem_we_o), 64'(0));
    compare_log("oor_log");

    // Stalled memory: five accepted (four queued plus one in flight), sixth dropped.
    mem_ack_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send(100 + k, 7, k, k + 1, k + 2);
      if (k < 5) expect_pix(100 + k, 7, k, k + 1, k + 2);
      if (k == 3) chk("stall_ready4", 64'(ready_o), 64'(1));
      if (k == 4) begin
        chk("stall_ready5", 64'(ready_o), 64'(0));
        chk("stall_ovf5", 64'(overflow_o), 64'(0));
        chk("stall_hold_addr", 64'(mem_addr_o), 64'(7 * W + 100));
      end
    end
    chk("stall_ovf6", 64'(overflow_o), 64'(1));
    chk("stall_we", 64'(mem_we_o), 64'(1));
    mem_ack_i = 1'b1;
    repeat (12) tick();
    chk("stall_ovf_sticky", 64'(overflow_o), 64'(1));
    compare_log("stall_log");

    // Reset in the middle of an outstanding write.
    mem_ack_i = 1'b0;
    send(1, 1, 1, 1, 1);
    send(2, 1, 1, 1, 1);
    send(3, 1, 1, 1, 1);
    tick();
    chk("rstw_we_before", 64'(mem_we_o), 64'(1));
    #2;
    n_rst = 1'b0;
    #1;
    chk("rstw_we_async", 64'(mem_we_o), 64'(0));
    chk("rstw_ovf", 64'(overflow_o), 64'(0));
    tick(); tick();
    n_rst = 1'b1;
    mem_ack_i = 1'b1;
    repeat (10) tick();
    chk("rstw_idle", 64'(idle_o), 64'(1));
    compare_log("rstw_log");

    // Randomized stream with random ack; valid is withheld only for in-range pixels when not ready.
    for (int c = 0; c < 400; c++) begin
      want = ($urandom_range(0, 3) != 0);
      oor  = ($urandom_range(0, 4) == 0);
      x = oor && $urandom_range(0, 1) ? int'($urandom_range(W, 1023)) : int'($urandom_range(0, W - 1));
      y = oor && (x < W) ? int'($urandom_range(H, 511)) : int'($urandom_range(0, H - 1));
      mem_ack_i = ($urandom_range(0, 2) != 0);
      if (want && (ready_o || oor)) begin
        drive(x, y, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        expect_pix(x, y, int'(r_i), int'(g_i), int'(b_i));
      end else begin
        pix_valid_i = 1'b0;
      end
      tick();
    end
    pix_valid_i = 1'b0;
    mem_ack_i = 1'b1;
    fd_cnt = 0;
    gen_done_i = 1'b1;
    tick();
    gen_done_i = 1'b0;
    repeat (30) tick();
    chk("rand_ovf", 64'(overflow_o), 64'(0));
    chk("rand_fd_pulses", 64'(fd_cnt), 64'(1));
    chk("rand_idle", 64'(idle_o), 64'(1));
    compare_log("rand_log");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_pixel_writer.md
GPU_PIXEL_WRITER -- requirements
Module: gpu_pixel_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning coordinate FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_BITS, default 20, meaning framebuffer word address width (must hold `WIDTH*`HEIGHT).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pix_valid_i  input  1  x_i/y_i/colour valid this cycle (driven by the rectangle generator's busy_o).
REQ-006 SHALL have ports x_i  input  `WIDTH_BITS and y_i  input  `HEIGHT_BITS  pixel coordinate.
REQ-007 SHALL have ports r_i, g_i, b_i  input  `CHANNEL_BITS each  pixel colour.
REQ-008 SHALL have port gen_done_i  input  1  generator finished the primitive (one-cycle pulse).
REQ-009 SHALL have port ready_o  output  1  FIFO can accept a pixel this cycle.
REQ-010 SHALL have port mem_addr_o  output  ADDR_BITS  framebuffer write address.
REQ-011 SHALL have port mem_data_o  output  3*`CHANNEL_BITS  write data {r,g,b}, r in MSBs.
REQ-012 SHALL have port mem_we_o  output  1  write request, held until acknowledged.
REQ-013 SHALL have port mem_ack_i  input  1  memory accepted the current write.
REQ-014 SHALL have port overflow_o  output  1  sticky: a valid pixel was dropped.
REQ-015 SHALL have port frame_done_o  output  1  one-cycle pulse: primitive fully written.
REQ-016 SHALL have port idle_o  output  1  nothing buffered, in flight, or pending.

Function
REQ-017 SHALL hold a FIFO_DEPTH-entry FIFO of {x,y,r,g,b} with a count of width clog2(FIFO_DEPTH)+1.
REQ-018 ready_o SHALL be combinational: count < FIFO_DEPTH.
REQ-019 On a rising edge with pix_valid_i=1, ready_o=1, x_i < `WIDTH and y_i < `HEIGHT, the pixel SHALL be pushed.
REQ-020 Pixels with x_i >= `WIDTH or y_i >= `HEIGHT SHALL be discarded silently: no push, no overflow.
REQ-021 pix_valid_i=1 with an in-range pixel while ready_o=0 SHALL drop the pixel and set overflow_o, which stays set until reset.
REQ-022 Write FSM SHALL have states IDLE and WRITE.
REQ-023 IDLE with FIFO non-empty: pop head, register mem_addr_o = y*`WIDTH + x (ADDR_BITS, unsigned, no truncation for legal coordinates), mem_data_o = {r,g,b}, mem_we_o=1, go to WRITE.
REQ-024 WRITE: mem_addr_o, mem_data_o and mem_we_o=1 SHALL stay stable until an edge samples mem_ack_i=1.
REQ-025 WRITE on ack with FIFO non-empty: pop and load the next pixel on the same edge, stay in WRITE with mem_we_o=1 (back-to-back, one write per cycle at full ack rate).
REQ-026 WRITE on ack with FIFO empty: mem_we_o=0, go to IDLE.
REQ-027 mem_ack_i SHALL be ignored in IDLE.
REQ-028 Latency: a pixel pushed at edge N into an empty FIFO with FSM in IDLE SHALL appear on the memory bus with mem_we_o=1 after edge N+1.
REQ-029 Push and pop on the same edge SHALL leave count unchanged; pixel order SHALL be strictly FIFO.
REQ-030 gen_done_i=1 SHALL set an internal done_pending flag.
REQ-031 frame_done_o SHALL be registered and pulse high for exactly one cycle on the edge after done_pending=1, FIFO empty, state IDLE and gen_done_i=0 all hold; done_pending clears on that edge.
REQ-032 A gen_done_i arriving while done_pending is already set SHALL merge into one frame_done_o pulse.
REQ-033 idle_o SHALL be combinational: state IDLE, FIFO empty, done_pending=0.

Reset
REQ-034 n_rst=0 SHALL immediately, asynchronously force FSM to IDLE and set: count=0, done_pending=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, overflow_o=0, frame_done_o=0.
REQ-035 Reset during WRITE SHALL abandon the outstanding write with no retry after reset release; FIFO contents are lost.

Verification
REQ-036 Single pixel (x=3,y=2, rgb=1/2/3), ack tied high -> one write: addr=2*`WIDTH+3, data={1,2,3}, mem_we_o high exactly one cycle.
REQ-037 2x2 rectangle stream then gen_done_i, ack tied high -> 4 writes in raster order, frame_done_o pulses once after the last ack, idle_o=1.
REQ-038 mem_ack_i held low, 6 consecutive valid pixels with FIFO_DEPTH=4 -> ready_o=0 after 5 pushes (4 in FIFO + 1 in flight), 6th dropped, overflow_o=1 and stays 1; after ack resumes, 5 writes are issued.
REQ-039 Pixel x=`WIDTH presented -> no write, overflow_o=0, count unchanged.
REQ-040 n_rst pulsed low while mem_we_o=1 with 2 pixels queued -> mem_we_o=0 during reset, no writes after release, idle_o=1.
